// File: rtl/dist_seq_ctrl.sv
// Sequencer for the Euclidean distance datapath: loads the query vector once, then
// walks candidates 1..N through load, clear, Pipe/Acc/Sqrt handshakes and emit.
module dist_seq_ctrl #(
  parameter int unsigned VECWIDTH   = 10,
  parameter int unsigned ADDRWIDTH  = 12,
  parameter int unsigned NUMWIDTH   = 8,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          ACC_PRESET = 1'b0
) (
  input  logic                        clk,
  input  logic                        RST_N,
  input  logic                        STARTCALC,
  input  logic [NUMWIDTH-1:0]         NUM_OF_VECTORS,
  input  logic                        RDY_Pipe,
  input  logic                        RDY_Acc,
  input  logic                        RDY_Sqrt,
  output logic [ADDRWIDTH-1:0]        ADDR_Bram,
  output logic [3:0]                  FLAG_Bram,
  output logic                        LD_EN,
  output logic [$clog2(VECWIDTH)-1:0] LD_IDX,
  output logic                        LD_SEL,
  output logic                        EN_Pipe,
  output logic                        EN_Acc,
  output logic                        EN_Sqrt,
  output logic                        RST_Acc,
  output logic                        RST_Sqrt,
  output logic                        PRE_Acc,
  output logic [NUMWIDTH-1:0]         VEC_IDX,
  output logic                        DIST_VALID,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR
);

  localparam int unsigned IDXW = $clog2(VECWIDTH);
  localparam int unsigned WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LDQ, S_LDC, S_CLR, S_PIPE, S_ACC, S_SQRT, S_EMIT, S_FIN, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      elem_q, elem_d;
  logic [NUMWIDTH-1:0]  n_q, n_d;
  logic [NUMWIDTH-1:0]  vec_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [ADDRWIDTH-1:0] addr_d;
  logic                 wait_c, rdy_c, rd_c;
  state_t               adv_c;

  // Next-state logic; candidates sit contiguously after the query, so the read
  // address is a running pointer equal to vec*VECWIDTH + elem modulo 2^ADDRWIDTH.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    n_d     = n_q;
    vec_d   = VEC_IDX;
    wd_d    = wd_q;
    addr_d  = ADDR_Bram;
    wait_c  = 1'b0;
    rdy_c   = 1'b0;
    adv_c   = state_q;
    case (state_q)
      S_IDLE: begin
        if (STARTCALC) begin
          n_d     = NUM_OF_VECTORS;
          vec_d   = '0;
          elem_d  = '0;
          addr_d  = '0;
          state_d = (NUM_OF_VECTORS == '0) ? S_FIN : S_LDQ;
        end
      end
      S_LDQ, S_LDC: begin
        addr_d = ADDR_Bram + ADDRWIDTH'(1);
        elem_d = elem_q + IDXW'(1);
        if (elem_q == IDXW'(VECWIDTH - 1)) begin
          elem_d = '0;
          if (state_q == S_LDQ) begin
            vec_d   = NUMWIDTH'(1);
            state_d = S_LDC;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR:  state_d = S_PIPE;
      S_PIPE: begin wait_c = 1'b1; rdy_c = RDY_Pipe; adv_c = S_ACC;  end
      S_ACC:  begin wait_c = 1'b1; rdy_c = RDY_Acc;  adv_c = S_SQRT; end
      S_SQRT: begin wait_c = 1'b1; rdy_c = RDY_Sqrt; adv_c = S_EMIT; end
      S_EMIT: begin
        if (VEC_IDX == n_q) begin
          state_d = S_FIN;
        end else begin
          vec_d   = VEC_IDX + NUMWIDTH'(1);
          state_d = S_LDC;
        end
      end
      S_FIN:  state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    // Handshake wait with watchdog; TIMEOUT == 0 never expires
    if (wait_c) begin
      if (rdy_c) begin
        state_d = adv_c;
      end else if ((TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1))) begin
        state_d = S_ERR;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
    if (state_d != state_q) wd_d = '0;
    rd_c = (state_d == S_LDQ) || (state_d == S_LDC);
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      elem_q     <= '0;
      n_q        <= '0;
      wd_q       <= '0;
      ADDR_Bram  <= '0;
      FLAG_Bram  <= '0;
      LD_EN      <= 1'b0;
      LD_IDX     <= '0;
      LD_SEL     <= 1'b0;
      EN_Pipe    <= 1'b0;
      EN_Acc     <= 1'b0;
      EN_Sqrt    <= 1'b0;
      RST_Acc    <= 1'b0;
      RST_Sqrt   <= 1'b0;
      PRE_Acc    <= 1'b0;
      VEC_IDX    <= '0;
      DIST_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      n_q        <= n_d;
      wd_q       <= wd_d;
      ADDR_Bram  <= addr_d;
      VEC_IDX    <= vec_d;
      FLAG_Bram  <= {rd_c, 1'b0, rd_c, state_d == S_LDQ};
      // BRAM returns data one cycle after the address phase
      LD_EN      <= FLAG_Bram[3];
      LD_IDX     <= elem_q;
      LD_SEL     <= FLAG_Bram[0];
      EN_Pipe    <= (state_d == S_PIPE);
      EN_Acc     <= (state_d == S_ACC);
      EN_Sqrt    <= (state_d == S_SQRT);
      RST_Acc    <= (state_d == S_CLR) && !ACC_PRESET;
      PRE_Acc    <= (state_d == S_CLR) && ACC_PRESET;
      RST_Sqrt   <= (state_d == S_CLR);
      DIST_VALID <= (state_d == S_EMIT);
      BUSY       <= state_d inside {S_LDQ, S_LDC, S_CLR, S_PIPE, S_ACC, S_SQRT, S_EMIT};
      DONE       <= (state_d == S_FIN);
      ERROR      <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_dist_seq_ctrl.sv
// Scoreboard bench for dist_seq_ctrl: expected reads, loads and emits are queued at
// stimulus time and checked as the sequencer produces them.
module tb_dist_seq_ctrl;

  logic        clk;
  logic        RST_N;
  logic        STARTCALC;
  logic [7:0]  NUM_OF_VECTORS;
  logic        RDY_Pipe, RDY_Acc, RDY_Sqrt;
  logic [11:0] ADDR_Bram;
  logic [3:0]  FLAG_Bram;
  logic        LD_EN;
  logic [3:0]  LD_IDX;
  logic        LD_SEL;
  logic        EN_Pipe, EN_Acc, EN_Sqrt;
  logic        RST_Acc, RST_Sqrt, PRE_Acc;
  logic [7:0]  VEC_IDX;
  logic        DIST_VALID, BUSY, DONE, ERROR;

  dist_seq_ctrl #(.VECWIDTH(10), .ADDRWIDTH(12), .NUMWIDTH(8), .TIMEOUT(8), .ACC_PRESET(1'b0)) dut (
    .clk(clk), .RST_N(RST_N), .STARTCALC(STARTCALC), .NUM_OF_VECTORS(NUM_OF_VECTORS),
    .RDY_Pipe(RDY_Pipe), .RDY_Acc(RDY_Acc), .RDY_Sqrt(RDY_Sqrt),
    .ADDR_Bram(ADDR_Bram), .FLAG_Bram(FLAG_Bram), .LD_EN(LD_EN), .LD_IDX(LD_IDX), .LD_SEL(LD_SEL),
    .EN_Pipe(EN_Pipe), .EN_Acc(EN_Acc), .EN_Sqrt(EN_Sqrt),
    .RST_Acc(RST_Acc), .RST_Sqrt(RST_Sqrt), .PRE_Acc(PRE_Acc),
    .VEC_IDX(VEC_IDX), .DIST_VALID(DIST_VALID), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_rd[$];
  logic [4:0]  exp_ld[$];
  logic [7:0]  exp_dv[$];
  int rd_cnt = 0, ld_cnt = 0, dv_cnt = 0, done_cnt = 0;
  int pipe_cyc = 0, acc_cyc = 0, sqrt_cyc = 0;
  int rdy_mode = 0;
  logic prev_cs = 1'b0, pv_pipe = 1'b0, pv_acc = 1'b0, pv_sqrt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ADDR_Bram, FLAG_Bram, LD_EN, LD_IDX, LD_SEL, EN_Pipe, EN_Acc, EN_Sqrt,
                RST_Acc, RST_Sqrt, PRE_Acc, VEC_IDX, DIST_VALID, BUSY, DONE, ERROR});
  endfunction

  // Expected traffic for a run that loads the query and candidates 1..last_vec
  task automatic push_loads(input int last_vec);
    for (int v = 0; v <= last_vec; v++) begin
      for (int e = 0; e < 10; e++) begin
        exp_rd.push_back({v == 0, 12'(v * 10 + e)});
        exp_ld.push_back({v == 0, 4'(e)});
      end
    end
  endtask

  // One clock: sample at the falling edge, check against the scoreboard, then drive RDYs
  task automatic tick();
    logic [12:0] r;
    logic [4:0]  l;
    logic [7:0]  d;
    @(negedge clk);
    chk("en_onehot", 64'($countones({EN_Pipe, EN_Acc, EN_Sqrt}) <= 1), 64'd1);
    chk("ld_en_lag", 64'(LD_EN), 64'(prev_cs));
    if (FLAG_Bram[3]) begin
      rd_cnt++;
      chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
      if (exp_rd.size() != 0) begin
        r = exp_rd.pop_front();
        chk("rd_addr_flag", 64'({FLAG_Bram, ADDR_Bram}), 64'({3'b101, r[12], r[11:0]}));
      end
    end
    if (LD_EN) begin
      ld_cnt++;
      chk("ld_expected", 64'(exp_ld.size() != 0), 64'd1);
      if (exp_ld.size() != 0) begin
        l = exp_ld.pop_front();
        chk("ld_sel_idx", 64'({LD_SEL, LD_IDX}), 64'(l));
      end
    end
    if (DIST_VALID) begin
      dv_cnt++;
      chk("dv_expected", 64'(exp_dv.size() != 0), 64'd1);
      if (exp_dv.size() != 0) begin
        d = exp_dv.pop_front();
        chk("dv_vec_idx", 64'(VEC_IDX), 64'(d));
      end
    end
    if (DONE) done_cnt++;
    if (EN_Pipe) pipe_cyc++;
    if (EN_Acc) acc_cyc++;
    if (EN_Sqrt) sqrt_cyc++;
    prev_cs  = FLAG_Bram[3];
    RDY_Pipe = (rdy_mode == 2) ? 1'b1 : (EN_Pipe && pv_pipe);
    RDY_Acc  = (rdy_mode == 1) ? 1'b0 : (EN_Acc && pv_acc);
    RDY_Sqrt = (rdy_mode == 3) ? 1'b0 : (EN_Sqrt && pv_sqrt);
    pv_pipe  = EN_Pipe;
    pv_acc   = EN_Acc;
    pv_sqrt  = EN_Sqrt;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (DONE) break;
    end
    chk(tag, 64'(DONE), 64'd1);
  endtask

  int b_rd, b_done, b_dv, b_pipe, b_acc, b_sqrt;

  task automatic snap();
    b_rd = rd_cnt; b_done = done_cnt; b_dv = dv_cnt;
    b_pipe = pipe_cyc; b_acc = acc_cyc; b_sqrt = sqrt_cyc;
  endtask

  initial begin
    RST_N = 1'b0; STARTCALC = 1'b0; NUM_OF_VECTORS = '0;
    RDY_Pipe = 1'b0; RDY_Acc = 1'b0; RDY_Sqrt = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 64'd0);
    RST_N = 1'b1;
    tick();

    // Two candidates, RDYs one cycle after each EN; N changed after start must not matter
    snap(); push_loads(2); exp_dv.push_back(8'd1); exp_dv.push_back(8'd2);
    NUM_OF_VECTORS = 8'd2; STARTCALC = 1'b1;
    tick();
    STARTCALC = 1'b0; NUM_OF_VECTORS = 8'd7;
    chk("t1_busy_after_start", 64'(BUSY), 64'd1);
    wait_done("t1_done_seen");
    tick(); tick();
    chk("t1_done_count", 64'(done_cnt - b_done), 64'd1);
    chk("t1_reads", 64'(rd_cnt - b_rd), 64'd30);
    chk("t1_emits", 64'(dv_cnt - b_dv), 64'd2);
    chk("t1_en_pipe_cycles", 64'(pipe_cyc - b_pipe), 64'd4);
    chk("t1_en_acc_cycles", 64'(acc_cyc - b_acc), 64'd4);
    chk("t1_busy_idle", 64'(BUSY), 64'd0);
    chk("t1_queues_empty", 64'(exp_rd.size() + exp_ld.size() + exp_dv.size()), 64'd0);

    // N = 0: DONE on the cycle after start, no reads, no stage enables
    snap();
    NUM_OF_VECTORS = 8'd0; STARTCALC = 1'b1;
    tick();
    STARTCALC = 1'b0;
    chk("t2_done_next_cycle", 64'(DONE), 64'd1);
    chk("t2_busy", 64'(BUSY), 64'd0);
    tick(); tick(); tick();
    chk("t2_no_reads", 64'(rd_cnt - b_rd), 64'd0);
    chk("t2_no_en", 64'((pipe_cyc - b_pipe) + (acc_cyc - b_acc) + (sqrt_cyc - b_sqrt)), 64'd0);
    chk("t2_done_count", 64'(done_cnt - b_done), 64'd1);

    // STARTCALC held high, RDY_Pipe stuck at 1
    snap(); push_loads(2); exp_dv.push_back(8'd1); exp_dv.push_back(8'd2);
    rdy_mode = 2; NUM_OF_VECTORS = 8'd2; STARTCALC = 1'b1;
    wait_done("t6_done_seen");
    STARTCALC = 1'b0;
    tick(); tick(); tick();
    rdy_mode = 0;
    chk("t6_done_count", 64'(done_cnt - b_done), 64'd1);
    chk("t6_reads", 64'(rd_cnt - b_rd), 64'd30);
    chk("t6_en_pipe_cycles", 64'(pipe_cyc - b_pipe), 64'd2);
    chk("t6_en_sqrt_cycles", 64'(sqrt_cyc - b_sqrt), 64'd4);
    chk("t6_busy_idle", 64'(BUSY), 64'd0);
    chk("t6_queues_empty", 64'(exp_rd.size() + exp_ld.size() + exp_dv.size()), 64'd0);

    // Asynchronous reset while waiting in SQRT for candidate 1 of 3
    snap(); push_loads(1);
    rdy_mode = 3; NUM_OF_VECTORS = 8'd3; STARTCALC = 1'b1;
    tick();
    STARTCALC = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (EN_Sqrt) break;
    end
    chk("t5_reached_sqrt", 64'(EN_Sqrt), 64'd1);
    tick();
    #1 RST_N = 1'b0;
    #1 chk("t5_async_reset_outputs", all_outs(), 64'd0);
    tick();
    RST_N = 1'b1; rdy_mode = 0;
    tick();
    chk("t5_no_done", 64'(done_cnt - b_done), 64'd0);
    chk("t5_queues_empty", 64'(exp_rd.size() + exp_ld.size() + exp_dv.size()), 64'd0);
    snap(); push_loads(1); exp_dv.push_back(8'd1);
    NUM_OF_VECTORS = 8'd1; STARTCALC = 1'b1;
    tick();
    STARTCALC = 1'b0;
    wait_done("t5_rerun_done_seen");
    tick();
    chk("t5_rerun_reads", 64'(rd_cnt - b_rd), 64'd20);
    chk("t5_rerun_emits", 64'(dv_cnt - b_dv), 64'd1);
    chk("t5_rerun_queues_empty", 64'(exp_rd.size() + exp_ld.size() + exp_dv.size()), 64'd0);

    // Watchdog: RDY_Acc never arrives, TIMEOUT = 8
    snap(); push_loads(1);
    rdy_mode = 1; NUM_OF_VECTORS = 8'd1; STARTCALC = 1'b1;
    tick();
    STARTCALC = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ERROR) break;
    end
    chk("t4_error_seen", 64'(ERROR), 64'd1);
    chk("t4_en_acc_cycles", 64'(acc_cyc - b_acc), 64'd8);
    chk("t4_all_en_low", 64'({EN_Pipe, EN_Acc, EN_Sqrt}), 64'd0);
    chk("t4_busy_low", 64'(BUSY), 64'd0);
    snap();
    STARTCALC = 1'b1; NUM_OF_VECTORS = 8'd1;
    tick();
    STARTCALC = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("t4_start_ignored_reads", 64'(rd_cnt - b_rd), 64'd0);
    chk("t4_error_sticky", 64'({ERROR, BUSY, DONE}), 64'b100);
    chk("t4_no_done", 64'(done_cnt - b_done), 64'd0);
    chk("t4_queues_empty", 64'(exp_rd.size() + exp_ld.size() + exp_dv.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
